booth_mult_seq: RTL and testbench
=================================

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 SHALL provide parameter A_W, default 12, multiplier width in bits; even, >= 4.
REQ-002 SHALL provide parameter B_W, default 12, multiplicand width in bits; >= 2.
REQ-003 SHALL provide derived localparam P_W = A_W + B_W, product width.
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL provide port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL provide port start  input  1  request to begin a multiplication.
REQ-007 SHALL provide port signed_mode  input  1  1 = operands two's complement, 0 = unsigned.
REQ-008 SHALL provide port mult_a  input  A_W  multiplier (Booth-recoded operand).
REQ-009 SHALL provide port mult_b  input  B_W  multiplicand.
REQ-010 SHALL provide port ready  output  1  high when in IDLE and able to accept start.
REQ-011 SHALL provide port busy  output  1  high while iterating (RUN).
REQ-012 SHALL provide port done  output  1  one-cycle pulse marking product valid.
REQ-013 SHALL provide port product  output  P_W  result, registered.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered or decoded from state only.
REQ-015 SHALL accept start only in IDLE: at that edge latch mult_a, mult_b, signed_mode, clear accumulator, clear digit counter, go to RUN.
REQ-016 SHALL ignore start (and operand changes) in RUN and DONE; latched operands are unaffected.
REQ-017 SHALL process one radix-4 Booth digit per RUN cycle, LSB digit first, digit i weighted 4^i.
REQ-018 SHALL form digit i from multiplier bits {a[2i+1], a[2i], a[2i-1]}, with a[-1] = 0.
REQ-019 SHALL encode digits: 000 -> 0, 001 -> +B, 010 -> +B, 011 -> +2B, 100 -> -2B, 101 -> -B, 110 -> -B, 111 -> 0.
REQ-020 SHALL sign-extend mult_b when signed_mode = 1 and zero-extend otherwise; -B formed as two's complement at full internal width.
REQ-021 SHALL zero-extend mult_a by 2 bits when signed_mode = 0 and sign-extend otherwise.
REQ-022 SHALL use N = A_W/2 digits when signed_mode = 1 and N = A_W/2 + 1 when signed_mode = 0.
REQ-023 SHALL size the internal accumulator to P_W + 2 bits so no intermediate overflow occurs; product = low P_W bits, exact for all operand values in both modes.
REQ-024 SHALL transition RUN -> DONE on the edge that processes digit N-1, updating product on that same edge.
REQ-025 SHALL assert done for exactly one cycle (state DONE), then return to IDLE unconditionally.
REQ-026 SHALL give latency: done high in the cycle after the N-th edge following the start-accepting edge (signed 12-bit: 6 edges; unsigned 12-bit: 7 edges).
REQ-027 SHALL hold product stable from the DONE edge until the edge completing the next operation; it does not change during RUN.
REQ-028 SHALL drive ready = (state == IDLE), busy = (state == RUN), done = (state == DONE); never two high simultaneously.
REQ-029 SHALL support back-to-back operations with minimum issue interval N + 2 cycles (start held high in IDLE is accepted immediately).

Reset
REQ-030 SHALL, when rst_n = 0 at a rising edge, force state IDLE, product = 0, done = 0, busy = 0, accumulator and counter = 0.
REQ-031 SHALL give rst_n priority over start; start with rst_n = 0 is not accepted.
REQ-032 SHALL abort an in-progress operation on reset mid-RUN: no done pulse, product = 0, ready = 1 the cycle after reset releases.

Verification
REQ-033 SHALL cover: signed, a = -2048, b = -2048 -> product 0x400000, done exactly 6 edges after accept, one cycle wide.
REQ-034 SHALL cover: unsigned, a = 4095, b = 4095 -> product 0xFFE001, done 7 edges after accept.
REQ-035 SHALL cover: signed, a = -1, b = 1 -> 0xFFFFFF; a = 0, b = -2048 -> 0x000000; a = 2047, b = -2048 -> 0xC00800.
REQ-036 SHALL cover: start pulsed with new operands during RUN -> ignored, first result unchanged, no extra done.
REQ-037 SHALL cover: rst_n low for one edge at RUN cycle 3 -> no done, product 0, ready high next cycle; new op then completes correctly.
REQ-038 SHALL cover: 1000 random operand pairs per mode, A_W = 12/B_W = 12 and A_W = 8/B_W = 16 -> product matches reference model, product stable between done pulses.

Source files
------------

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
//   Sequential radix-4 Booth multiplier. One Booth digit of the multiplier is
//   retired per clock, LSB digit first, so a signed A_W-bit multiply takes
//   A_W/2 iterations and an unsigned one takes A_W/2 + 1 iterations, because
//   the extra digit absorbs the zero-extended MSB.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   start        begin a multiplication (honoured only while ready)
//   signed_mode  1: operands are two's complement, 0: unsigned
//   mult_a       multiplier (Booth-recoded operand), A_W bits
//   mult_b       multiplicand, B_W bits
//   ready        idle and able to accept start
//   busy         iterating
//   done         one-cycle pulse, product valid
//   product      registered result, A_W + B_W bits
// -----------------------------------------------------------------------------
module booth_mult_seq #(
  parameter  int A_W = 12,
  parameter  int B_W = 12,
  localparam int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [A_W-1:0] mult_a,
  input  logic [B_W-1:0] mult_b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product
);

  // Two guard bits keep every partial sum exact; the multiplier register
  // carries two extension bits on top and the implicit a[-1] = 0 below.
  localparam int ACC_W = P_W + 2;
  localparam int AX_W  = A_W + 3;
  localparam int CNT_W = $clog2(A_W / 2 + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [AX_W-1:0]          a_sh;
  logic signed [ACC_W-1:0]  b_sh;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  pp;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic                     smode;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         last_cnt;
  logic                     last_dig;

  // Radix-4 Booth digit to partial product, relative to the current digit
  // weight (b_sh already carries the 4^i scaling).
  function automatic logic signed [ACC_W-1:0] booth_pp(
    input logic [2:0]              dig,
    input logic signed [ACC_W-1:0] b
  );
    case (dig)
      3'b001, 3'b010: booth_pp = b;
      3'b011:         booth_pp = b <<< 1;
      3'b100:         booth_pp = -(b <<< 1);
      3'b101, 3'b110: booth_pp = -b;
      default:        booth_pp = '0;
    endcase
  endfunction

  always_comb begin
    pp       = booth_pp(a_sh[2:0], b_sh);
    acc_nxt  = acc + pp;
    last_cnt = smode ? CNT_W'(A_W / 2 - 1) : CNT_W'(A_W / 2);
    last_dig = (cnt == last_cnt);
  end

  // ---- control: state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_dig) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

  // ---- operand capture and per-digit shifting (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      a_sh  <= {{2{signed_mode & mult_a[A_W-1]}}, mult_a, 1'b0};
      b_sh  <= {{(ACC_W-B_W){signed_mode & mult_b[B_W-1]}}, mult_b};
      smode <= signed_mode;
    end else if (state_q == RUN) begin
      a_sh  <= a_sh >> 2;
      b_sh  <= b_sh <<< 2;
    end
  end

  // ---- accumulate, count digits, publish product on the last digit ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last_dig) product <= acc_nxt[P_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
//   Directed-vector and reference-model bench for booth_mult_seq. Two
//   instances are exercised together: the default 12x12 and an 8x16 build.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [11:0] mult_a;
  logic [11:0] mult_b;
  logic [7:0]  mult_a2;
  logic [15:0] mult_b2;
  logic        ready, busy, done;
  logic        ready2, busy2, done2;
  logic [23:0] product;
  logic [23:0] product2;

  int n_cmp = 0;
  int n_err = 0;

  booth_mult_seq #(.A_W(12), .B_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .mult_a(mult_a), .mult_b(mult_b),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );

  booth_mult_seq #(.A_W(8), .B_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .mult_a(mult_a2), .mult_b(mult_b2),
    .ready(ready2), .busy(busy2), .done(done2), .product(product2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic longint ref_prod(input int aw, input int bw, input bit sm,
                                      input longint a, input longint b);
    longint sa, sb;
    sa = a;
    sb = b;
    if (sm && a[aw-1]) sa = a - (longint'(1) << aw);
    if (sm && b[bw-1]) sb = b - (longint'(1) << bw);
    return (sa * sb) & ((longint'(1) << (aw + bw)) - 1);
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!(ready && ready2) && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!(ready && ready2)) chk("idle_timeout", 64'(ready && ready2), 64'd1);
  endtask

  // One operation on both instances. Latency counts rising edges after the
  // accepting edge up to the one after which done is seen; operands are
  // scrambled after acceptance to prove they were latched.
  task automatic do_op(input bit sm, input logic [11:0] a, input logic [11:0] b,
                       input logic [7:0] a2, input logic [15:0] b2,
                       output logic [23:0] p1, output int lat1, output int nd1,
                       output logic [23:0] p2, output int lat2, output int nd2,
                       output bit bad);
    logic [23:0] prev1, prev2;
    bit seen1, seen2;
    wait_idle();
    prev1 = product;  prev2 = product2;
    p1 = prev1;       p2 = prev2;
    lat1 = -1; lat2 = -1; nd1 = 0; nd2 = 0;
    seen1 = 0; seen2 = 0; bad = 0;
    start = 1'b1; signed_mode = sm;
    mult_a = a; mult_b = b; mult_a2 = a2; mult_b2 = b2;
    @(negedge clk);
    start = 1'b0; signed_mode = ~sm;
    mult_a = ~a; mult_b = ~b; mult_a2 = ~a2; mult_b2 = ~b2;
    for (int n = 0; n <= 11; n++) begin
      if (n > 0) @(negedge clk);
      if (int'(ready) + int'(busy) + int'(done) != 1) bad = 1;
      if (int'(ready2) + int'(busy2) + int'(done2) != 1) bad = 1;
      if (done) begin
        nd1++;
        if (!seen1) begin lat1 = n; p1 = product; seen1 = 1; end
      end else if (!seen1 && product !== prev1) bad = 1;
      if (seen1 && product !== p1) bad = 1;
      if (done2) begin
        nd2++;
        if (!seen2) begin lat2 = n; p2 = product2; seen2 = 1; end
      end else if (!seen2 && product2 !== prev2) bad = 1;
      if (seen2 && product2 !== p2) bad = 1;
    end
  endtask

  typedef struct {
    bit          sm;
    logic [11:0] a;
    logic [11:0] b;
    logic [23:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[12];
  logic [23:0] p1, p2;
  int          lat1, lat2, nd1, nd2;
  bit          bad;
  logic [7:0]  a2;
  logic [15:0] b2;
  int          nd, first_d, second_d;

  initial begin
    vecs[0]  = '{1'b1, 12'h800, 12'h800, 24'h400000, 6};
    vecs[1]  = '{1'b0, 12'hFFF, 12'hFFF, 24'hFFE001, 7};
    vecs[2]  = '{1'b1, 12'hFFF, 12'h001, 24'hFFFFFF, 6};
    vecs[3]  = '{1'b1, 12'h000, 12'h800, 24'h000000, 6};
    vecs[4]  = '{1'b1, 12'h7FF, 12'h800, 24'hC00800, 6};
    vecs[5]  = '{1'b0, 12'h800, 12'h800, 24'h400000, 7};
    vecs[6]  = '{1'b1, 12'h003, 12'h005, 24'h00000F, 6};
    vecs[7]  = '{1'b0, 12'hFFF, 12'h001, 24'h000FFF, 7};
    vecs[8]  = '{1'b1, 12'h800, 12'h7FF, 24'hC00800, 6};
    vecs[9]  = '{1'b0, 12'hAAA, 12'h555, 24'h38DC72, 7};
    vecs[10] = '{1'b1, 12'hAAA, 12'h555, 24'hE38C72, 6};
    vecs[11] = '{1'b1, 12'h7FF, 12'h7FF, 24'h3FF001, 6};

    // Reset state, with start held high to show reset wins.
    rst_n = 1'b0; start = 1'b1; signed_mode = 1'b1;
    mult_a = 12'h123; mult_b = 12'h456; mult_a2 = 8'h12; mult_b2 = 16'h3456;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_ready2", 64'(ready2), 64'd1);
    chk("rst_product2", 64'(product2), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      a2 = vecs[i].a[11:4];
      b2 = {vecs[i].b, vecs[i].a[3:0]};
      do_op(vecs[i].sm, vecs[i].a, vecs[i].b, a2, b2, p1, lat1, nd1, p2, lat2, nd2, bad);
      chk($sformatf("vec%0d_product", i), 64'(p1), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 64'(lat1), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_done_pulses", i), 64'(nd1), 64'd1);
      chk($sformatf("vec%0d_product_8x16", i), 64'(p2),
          64'(ref_prod(8, 16, vecs[i].sm, longint'(a2), longint'(b2))));
      chk($sformatf("vec%0d_latency_8x16", i), 64'(lat2), vecs[i].sm ? 64'd4 : 64'd5);
      chk($sformatf("vec%0d_hold_onehot", i), 64'(bad), 64'd0);
    end

    // Start pulsed with new operands during RUN is ignored.
    wait_idle();
    start = 1'b1; signed_mode = 1'b1; mult_a = 12'h003; mult_b = 12'h005;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; mult_a = 12'h7FF; mult_b = 12'h7FF;
    @(negedge clk); start = 1'b0;
    nd = 0;
    if (done) nd++;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) begin nd++; p1 = product; end
    end
    chk("ignore_start_done_pulses", 64'(nd), 64'd1);
    chk("ignore_start_product", 64'(p1), 64'h00000F);

    // Start held high in IDLE: issue interval N + 2 for signed 12-bit.
    wait_idle();
    start = 1'b1; signed_mode = 1'b1; mult_a = 12'h003; mult_b = 12'h005;
    first_d = -1; second_d = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin
        if (first_d < 0) first_d = n;
        else if (second_d < 0) second_d = n;
      end
    end
    start = 1'b0;
    chk("back_to_back_interval", 64'(second_d - first_d), 64'd8);

    // Reset asserted for one edge in RUN cycle 3 aborts the operation.
    wait_idle();
    start = 1'b1; signed_mode = 1'b1; mult_a = 12'h7FF; mult_b = 12'h800;
    mult_a2 = 8'h7F; mult_b2 = 16'h8000;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_product", 64'(product), 64'd0);
    nd = 0;
    for (int n = 0; n < 10; n++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    do_op(1'b1, 12'h7FF, 12'h800, 8'h80, 16'h7FFF, p1, lat1, nd1, p2, lat2, nd2, bad);
    chk("after_abort_product", 64'(p1), 64'hC00800);
    chk("after_abort_latency", 64'(lat1), 64'd6);
    chk("after_abort_product_8x16", 64'(p2), 64'(ref_prod(8, 16, 1'b1, 64'h80, 64'h7FFF)));

    // Random operand pairs against the reference model, both modes.
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 1000; k++) begin
        logic [11:0] ra, rb;
        ra = 12'($urandom);
        rb = 12'($urandom);
        a2 = 8'($urandom);
        b2 = 16'($urandom);
        do_op(bit'(m), ra, rb, a2, b2, p1, lat1, nd1, p2, lat2, nd2, bad);
        chk("rnd_product", 64'(p1), 64'(ref_prod(12, 12, bit'(m), longint'(ra), longint'(rb))));
        chk("rnd_product_8x16", 64'(p2), 64'(ref_prod(8, 16, bit'(m), longint'(a2), longint'(b2))));
        chk("rnd_latency", 64'(lat1), (m == 1) ? 64'd6 : 64'd7);
        chk("rnd_latency_8x16", 64'(lat2), (m == 1) ? 64'd4 : 64'd5);
        chk("rnd_hold_onehot_pulse", 64'(bad || nd1 != 1 || nd2 != 1), 64'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
